// File: rtl/tl_ul_ahb_manager_bridge_pkg.sv
// Shared types for the TL-UL device to AHB-Lite manager bridge: TL-UL opcodes,
// AHB encodings, channel structs and the bridge state enum.
package tl_ul_ahb_manager_bridge_pkg;

    localparam int TL_DW     = 32;
    localparam int TL_AW     = 32;
    localparam int TL_SZW    = 2;
    localparam int TL_AIW    = 8;
    localparam int TL_SNKW   = 1;
    localparam int TL_DBW    = TL_DW / 8;
    localparam int TL_SZ_MAX = $clog2(TL_DBW);

    localparam int AHB_DW = 32;
    localparam int AHB_AW = 32;

    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET         = 3'd4;
    localparam logic [2:0] TL_D_ACK         = 3'd0;
    localparam logic [2:0] TL_D_ACK_DATA    = 3'd1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef struct packed {
        logic                 a_valid;
        logic [2:0]           a_opcode;
        logic [2:0]           a_param;
        logic [TL_SZW-1:0]    a_size;
        logic [TL_AIW-1:0]    a_source;
        logic [TL_AW-1:0]     a_address;
        logic [TL_DBW-1:0]    a_mask;
        logic [TL_DW-1:0]     a_data;
        logic                 d_ready;
    } tl_m2s_t;

    typedef struct packed {
        logic                 a_ready;
        logic                 d_valid;
        logic [2:0]           d_opcode;
        logic [2:0]           d_param;
        logic [TL_SZW-1:0]    d_size;
        logic [TL_AIW-1:0]    d_source;
        logic [TL_SNKW-1:0]   d_sink;
        logic [TL_DW-1:0]     d_data;
        logic                 d_error;
    } tl_s2m_t;

    typedef struct packed {
        logic [AHB_DW-1:0]    hrdata;
        logic                 hready;
        logic                 hresp;
    } h_manager_in_t;

    typedef struct packed {
        logic [AHB_AW-1:0]    haddr;
        logic                 hwrite;
        logic [2:0]           hsize;
        logic [2:0]           hburst;
        logic [3:0]           hprot;
        logic [1:0]           htrans;
        logic                 hmastlock;
        logic [AHB_DW-1:0]    hwdata;
    } h_manager_out_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } bridge_state_e;

    // Byte-lane offset bits that must be zero for an access of 2**sz bytes.
    function automatic logic [TL_SZ_MAX-1:0] size_low_mask(input logic [TL_SZW-1:0] sz);
        return TL_SZ_MAX'((32'd1 << sz) - 32'd1);
    endfunction

endpackage

// File: rtl/tl_ul_ahb_manager_bridge_if.sv
// Bundles the TL-UL channels and AHB-Lite manager signals seen by the bridge.
interface tl_ul_ahb_manager_bridge_if;
    import tl_ul_ahb_manager_bridge_pkg::*;

    tl_m2s_t        tl_i;
    tl_s2m_t        tl_o;
    h_manager_in_t  ahb_i;
    h_manager_out_t ahb_o;

    modport slave  (input tl_i, ahb_i, output tl_o, ahb_o);
    modport master (output tl_i, ahb_i, input tl_o, ahb_o);
endinterface

// File: rtl/tl_ul_ahb_manager_bridge_mask.sv
// Maps a TL-UL byte mask onto a single AHB transfer: a contiguous, naturally
// aligned run inside the request's size window gives its hsize and start lane.
module tl_mask_to_ahb_size #(
    parameter int NB  = 4,
    parameter int SZW = 2
) (
    input  logic [NB-1:0]         mask,
    input  logic [$clog2(NB)-1:0] addr_low,
    input  logic [SZW-1:0]        size,
    output logic                  valid,
    output logic [2:0]            hsize,
    output logic [$clog2(NB)-1:0] haddr_low
);
    localparam int LW = $clog2(NB);

    int            base;
    logic [NB-1:0] window;

    always_comb begin
        base      = int'(addr_low) & ~((1 << size) - 1);
        window    = NB'(((1 << (1 << size)) - 1) << base);
        valid     = 1'b0;
        hsize     = '0;
        haddr_low = '0;
        for (int sz = 0; (1 << sz) <= NB; sz++) begin
            for (int off = 0; off < NB; off += (1 << sz)) begin
                if (mask == NB'(((1 << (1 << sz)) - 1) << off)) begin
                    valid     = 1'b1;
                    hsize     = 3'(sz);
                    haddr_low = LW'(off);
                end
            end
        end
        if ((mask & ~window) != '0) begin
            valid = 1'b0;
        end
    end
endmodule

// File: rtl/tl_ul_ahb_manager_bridge.sv
// TL-UL device to AHB-Lite manager bridge, one outstanding transaction.
// state | meaning
// IDLE  | a_ready high, waiting for an A request
// ADDR  | AHB address phase, NONSEQ held until hready
// DATA  | AHB data phase, response captured on hready
// RESP  | D beat valid, held until d_ready
module tl_ul_ahb_manager_bridge
    import tl_ul_ahb_manager_bridge_pkg::*;
#(
    parameter logic [TL_SNKW-1:0] SinkId = '0,
    parameter logic [3:0]         HProt  = 4'b0011
) (
    input logic                       clk_i,
    input logic                       rst_i,
    tl_ul_ahb_manager_bridge_if.slave bus
);
    if (AHB_DW != TL_DW) begin : g_dw_check
        $fatal(1, "tl_ul_ahb_manager_bridge: AHB_DW must equal TL_DW");
    end

    tl_m2s_t       tl_a;
    h_manager_in_t ahb_in;
    assign tl_a   = bus.tl_i;
    assign ahb_in = bus.ahb_i;

    logic unused_a_param;
    assign unused_a_param = ^tl_a.a_param;

    bridge_state_e         state;
    logic [AHB_AW-1:0]     haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [1:0]            htrans_q;
    logic [AHB_DW-1:0]     hwdata_q;
    logic [TL_DW-1:0]      wdata_q;
    logic                  d_valid_q;
    logic [2:0]            d_opcode_q;
    logic [TL_SZW-1:0]     d_size_q;
    logic [TL_AIW-1:0]     d_source_q;
    logic [TL_DW-1:0]      d_data_q;
    logic                  d_error_q;

    logic                  mask_ok;
    logic [2:0]            pp_hsize;
    logic [TL_SZ_MAX-1:0]  pp_low;
    logic                  req_ok;
    logic [2:0]            req_size;
    logic [AHB_AW-1:0]     req_addr;

    tl_mask_to_ahb_size #(
        .NB  (TL_DBW),
        .SZW (TL_SZW)
    ) u_mask (
        .mask      (tl_a.a_mask),
        .addr_low  (tl_a.a_address[TL_SZ_MAX-1:0]),
        .size      (tl_a.a_size),
        .valid     (mask_ok),
        .hsize     (pp_hsize),
        .haddr_low (pp_low)
    );

    always_comb begin
        req_ok   = 1'b1;
        req_size = 3'(tl_a.a_size);
        req_addr = tl_a.a_address;
        if (tl_a.a_size > TL_SZW'(TL_SZ_MAX)) begin
            req_ok = 1'b0;
        end
        if ((tl_a.a_address[TL_SZ_MAX-1:0] & size_low_mask(tl_a.a_size)) != '0) begin
            req_ok = 1'b0;
        end
        if (tl_a.a_opcode == TL_A_PUT_PARTIAL) begin
            req_ok   = req_ok && mask_ok;
            req_size = pp_hsize;
            req_addr = {tl_a.a_address[TL_AW-1:TL_SZ_MAX], pp_low};
        end else if (tl_a.a_opcode != TL_A_GET && tl_a.a_opcode != TL_A_PUT_FULL) begin
            req_ok = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= '0;
            htrans_q   <= HTRANS_IDLE;
            hwdata_q   <= '0;
            wdata_q    <= '0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tl_a.a_valid) begin
                        d_source_q <= tl_a.a_source;
                        d_size_q   <= tl_a.a_size;
                        d_opcode_q <= (tl_a.a_opcode == TL_A_GET) ? TL_D_ACK_DATA : TL_D_ACK;
                        wdata_q    <= tl_a.a_data;
                        if (req_ok) begin
                            state    <= ST_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= req_addr;
                            hsize_q  <= req_size;
                            hwrite_q <= (tl_a.a_opcode != TL_A_GET);
                        end else begin
                            // Malformed request: answer with an error, never touch AHB.
                            state     <= ST_RESP;
                            d_valid_q <= 1'b1;
                            d_error_q <= 1'b1;
                            d_data_q  <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (ahb_in.hready) begin
                        state    <= ST_DATA;
                        htrans_q <= HTRANS_IDLE;
                        if (hwrite_q) begin
                            hwdata_q <= wdata_q;
                        end
                    end
                end
                ST_DATA: begin
                    if (ahb_in.hready) begin
                        state     <= ST_RESP;
                        d_valid_q <= 1'b1;
                        d_error_q <= ahb_in.hresp;
                        d_data_q  <= (!hwrite_q && !ahb_in.hresp) ? ahb_in.hrdata : '0;
                        haddr_q   <= '0;
                        hwrite_q  <= 1'b0;
                        hsize_q   <= '0;
                        hwdata_q  <= '0;
                    end
                end
                ST_RESP: begin
                    if (tl_a.d_ready) begin
                        state     <= ST_IDLE;
                        d_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tl_o = '{
        a_ready:  (state == ST_IDLE) && !rst_i,
        d_valid:  d_valid_q,
        d_opcode: d_opcode_q,
        d_param:  3'b000,
        d_size:   d_size_q,
        d_source: d_source_q,
        d_sink:   SinkId,
        d_data:   d_data_q,
        d_error:  d_error_q
    };

    assign bus.ahb_o = '{
        haddr:     haddr_q,
        hwrite:    hwrite_q,
        hsize:     hsize_q,
        hburst:    HBURST_SINGLE,
        hprot:     HProt,
        htrans:    htrans_q,
        hmastlock: 1'b0,
        hwdata:    hwdata_q
    };
endmodule

// File: tb/tb_tl_ul_ahb_manager_bridge.sv
// Bench for the TL-UL to AHB-Lite bridge: directed cases plus random requests
// checked against a request-level model of the bridge's classification rules.
module tb_tl_ul_ahb_manager_bridge;
    import tl_ul_ahb_manager_bridge_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    tl_ul_ahb_manager_bridge_if bus_if ();

    tl_ul_ahb_manager_bridge dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [7:0]  src;
        int          aw;
        int          dw;
        bit          herr;
        logic [31:0] rdata;
        int          rd;
    } txn_t;

    typedef struct {
        bit          err;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        bit          write;
    } exp_t;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                                input int aw, input int dw, input bit herr, input logic [31:0] rdata,
                                input int rd);
        txn_t t;
        t.op = op; t.size = size; t.addr = addr; t.mask = mask; t.data = data; t.src = src;
        t.aw = aw; t.dw = dw; t.herr = herr; t.rdata = rdata; t.rd = rd;
        return t;
    endfunction

    // Request-level reference: legality, AHB address and size of the single transfer.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        int   cnt;
        int   first;
        int   base;
        int   span;
        e.err   = 1'b0;
        e.haddr = t.addr;
        e.hsize = 3'(t.size);
        e.write = (t.op != 3'd4);
        if (t.op != 3'd4 && t.op != 3'd0 && t.op != 3'd1) e.err = 1'b1;
        if (t.size > 2) e.err = 1'b1;
        else if (t.addr % (32'd1 << t.size) != 0) e.err = 1'b1;
        if (t.op == 3'd1 && !e.err) begin
            cnt   = $countones(t.mask);
            first = 0;
            while (first < 4 && !t.mask[first]) first++;
            span = 1 << t.size;
            base = int'(t.addr % 4);
            if (cnt == 0 || (cnt & (cnt - 1)) != 0 || first % cnt != 0 ||
                (int'(t.mask) >> first) != (1 << cnt) - 1 ||
                first < base || first + cnt > base + span) begin
                e.err = 1'b1;
            end else begin
                e.hsize = 3'($clog2(cnt));
                e.haddr = {t.addr[31:2], 2'(first)};
            end
        end
        return e;
    endfunction

    // Called at a negedge with the bridge idle; returns at the negedge after the D handshake.
    task automatic run_txn(input txn_t t);
        exp_t        e;
        bit          exp_error;
        logic [31:0] exp_data;
        logic [31:0] exp_wdata;
        e         = model(t);
        exp_error = e.err || t.herr;
        exp_data  = (t.op == 3'd4 && !exp_error) ? t.rdata : 32'h0;
        exp_wdata = e.write ? t.data : 32'h0;

        chk_eq("a_ready_idle", bus_if.tl_o.a_ready, 1);
        bus_if.tl_i.a_valid   = 1'b1;
        bus_if.tl_i.a_opcode  = t.op;
        bus_if.tl_i.a_param   = 3'($urandom_range(0, 7));
        bus_if.tl_i.a_size    = t.size;
        bus_if.tl_i.a_source  = t.src;
        bus_if.tl_i.a_address = t.addr;
        bus_if.tl_i.a_mask    = t.mask;
        bus_if.tl_i.a_data    = t.data;
        bus_if.tl_i.d_ready   = 1'b0;
        bus_if.ahb_i.hready   = 1'b1;
        bus_if.ahb_i.hresp    = 1'b0;
        @(negedge clk_i);
        bus_if.tl_i.a_valid = 1'b0;

        if (!e.err) begin
            chk_eq("htrans_nonseq", bus_if.ahb_o.htrans, HTRANS_NONSEQ);
            chk_eq("haddr", bus_if.ahb_o.haddr, e.haddr);
            chk_eq("hsize", bus_if.ahb_o.hsize, e.hsize);
            chk_eq("hwrite", bus_if.ahb_o.hwrite, e.write);
            chk_eq("a_ready_busy", bus_if.tl_o.a_ready, 0);
            chk_eq("d_valid_addr", bus_if.tl_o.d_valid, 0);
            for (int i = 0; i < t.aw; i++) begin
                bus_if.ahb_i.hready = 1'b0;
                @(negedge clk_i);
                chk_eq("htrans_hold", bus_if.ahb_o.htrans, HTRANS_NONSEQ);
                chk_eq("haddr_hold", bus_if.ahb_o.haddr, e.haddr);
                chk_eq("hsize_hold", bus_if.ahb_o.hsize, e.hsize);
            end
            bus_if.ahb_i.hready = 1'b1;
            @(negedge clk_i);
            chk_eq("htrans_data", bus_if.ahb_o.htrans, HTRANS_IDLE);
            chk_eq("hwdata", bus_if.ahb_o.hwdata, exp_wdata);
            chk_eq("d_valid_data", bus_if.tl_o.d_valid, 0);
            for (int i = 0; i < t.dw; i++) begin
                bus_if.ahb_i.hready = 1'b0;
                bus_if.ahb_i.hresp  = t.herr && (i == t.dw - 1);
                @(negedge clk_i);
                chk_eq("hwdata_hold", bus_if.ahb_o.hwdata, exp_wdata);
                chk_eq("d_valid_wait", bus_if.tl_o.d_valid, 0);
            end
            bus_if.ahb_i.hready = 1'b1;
            bus_if.ahb_i.hresp  = t.herr;
            bus_if.ahb_i.hrdata = t.rdata;
            @(negedge clk_i);
            bus_if.ahb_i.hresp = 1'b0;
        end

        for (int i = 0; i <= t.rd; i++) begin
            chk_eq("d_valid", bus_if.tl_o.d_valid, 1);
            chk_eq("d_opcode", bus_if.tl_o.d_opcode, (t.op == 3'd4) ? 1 : 0);
            chk_eq("d_error", bus_if.tl_o.d_error, exp_error);
            chk_eq("d_data", bus_if.tl_o.d_data, exp_data);
            chk_eq("d_source", bus_if.tl_o.d_source, t.src);
            chk_eq("d_size", bus_if.tl_o.d_size, t.size);
            chk_eq("d_param", bus_if.tl_o.d_param, 0);
            chk_eq("d_sink", bus_if.tl_o.d_sink, 0);
            chk_eq("a_ready_resp", bus_if.tl_o.a_ready, 0);
            chk_eq("htrans_resp", bus_if.ahb_o.htrans, HTRANS_IDLE);
            if (i < t.rd) begin
                bus_if.tl_i.a_valid = 1'b1;
                bus_if.ahb_i.hrdata = $urandom;
                @(negedge clk_i);
            end
        end
        bus_if.tl_i.a_valid = 1'b0;
        bus_if.tl_i.d_ready = 1'b1;
        @(negedge clk_i);
        bus_if.tl_i.d_ready = 1'b0;
        chk_eq("d_valid_done", bus_if.tl_o.d_valid, 0);
        chk_eq("haddr_idle", bus_if.ahb_o.haddr, 0);
        chk_eq("hwdata_idle", bus_if.ahb_o.hwdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        txn_t        t;
        logic [3:0]  good_masks [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        logic [2:0]  bad_ops [5]    = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        int          r;

        bus_if.tl_i  = '0;
        bus_if.ahb_i = '{hrdata: 32'h0, hready: 1'b1, hresp: 1'b0};
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk_eq("rst_htrans", bus_if.ahb_o.htrans, HTRANS_IDLE);
        chk_eq("rst_hwrite", bus_if.ahb_o.hwrite, 0);
        chk_eq("rst_haddr", bus_if.ahb_o.haddr, 0);
        chk_eq("rst_hsize", bus_if.ahb_o.hsize, 0);
        chk_eq("rst_hwdata", bus_if.ahb_o.hwdata, 0);
        chk_eq("rst_hburst", bus_if.ahb_o.hburst, 0);
        chk_eq("rst_hmastlock", bus_if.ahb_o.hmastlock, 0);
        chk_eq("rst_hprot", bus_if.ahb_o.hprot, 4'b0011);
        chk_eq("rst_d_valid", bus_if.tl_o.d_valid, 0);
        chk_eq("rst_a_ready", bus_if.tl_o.a_ready, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_txn(mk(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, 8'd3, 0, 0, 1'b0, 32'hDEADBEEF, 0));
        run_txn(mk(3'd0, 2'd2, 32'h204, 4'hF, 32'h12345678, 8'd5, 0, 2, 1'b0, 32'hCAFEF00D, 0));
        run_txn(mk(3'd1, 2'd2, 32'h300, 4'b1100, 32'hAABBCCDD, 8'd7, 0, 0, 1'b0, 32'h0, 0));
        run_txn(mk(3'd1, 2'd2, 32'h300, 4'b1010, 32'hAABBCCDD, 8'd8, 0, 0, 1'b0, 32'h0, 0));
        run_txn(mk(3'd4, 2'd2, 32'h40, 4'hF, 32'h0, 8'd9, 0, 1, 1'b1, 32'h55AA55AA, 0));
        run_txn(mk(3'd4, 2'd2, 32'h80, 4'hF, 32'h0, 8'd10, 1, 0, 1'b0, 32'h0BADCAFE, 5));
        run_txn(mk(3'd4, 2'd1, 32'h81, 4'hF, 32'h0, 8'd11, 0, 0, 1'b0, 32'h1, 0));
        run_txn(mk(3'd6, 2'd0, 32'h90, 4'h1, 32'h0, 8'd12, 0, 0, 1'b0, 32'h1, 0));
        run_txn(mk(3'd0, 2'd3, 32'h88, 4'hF, 32'h0, 8'd13, 0, 0, 1'b0, 32'h1, 0));

        // Reset while the data phase is stalled: transfer must be dropped.
        bus_if.tl_i.a_valid   = 1'b1;
        bus_if.tl_i.a_opcode  = 3'd4;
        bus_if.tl_i.a_size    = 2'd2;
        bus_if.tl_i.a_address = 32'h500;
        bus_if.tl_i.a_source  = 8'd20;
        @(negedge clk_i);
        bus_if.tl_i.a_valid = 1'b0;
        chk_eq("rstmid_nonseq", bus_if.ahb_o.htrans, HTRANS_NONSEQ);
        @(negedge clk_i);
        bus_if.ahb_i.hready = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_eq("rstmid_htrans", bus_if.ahb_o.htrans, HTRANS_IDLE);
        chk_eq("rstmid_d_valid", bus_if.tl_o.d_valid, 0);
        chk_eq("rstmid_a_ready", bus_if.tl_o.a_ready, 0);
        rst_i = 1'b0;
        bus_if.ahb_i.hready = 1'b1;
        @(negedge clk_i);
        chk_eq("rstmid_a_ready_after", bus_if.tl_o.a_ready, 1);
        repeat (2) begin
            @(negedge clk_i);
            chk_eq("rstmid_no_resp", bus_if.tl_o.d_valid, 0);
        end

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      t.op = 3'd4;
            else if (r < 5) t.op = 3'd0;
            else if (r < 9) t.op = 3'd1;
            else            t.op = bad_ops[$urandom_range(0, 4)];
            t.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            t.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
            t.mask  = ($urandom_range(0, 1) == 1) ? good_masks[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
            t.data  = $urandom;
            t.src   = 8'($urandom_range(0, 255));
            t.aw    = ($urandom_range(0, 3) == 0) ? 1 : 0;
            t.herr  = ($urandom_range(0, 5) == 0);
            t.dw    = $urandom_range(0, 2);
            if (t.herr && t.dw == 0) t.dw = 1;
            t.rdata = $urandom;
            t.rd    = $urandom_range(0, 2);
            run_txn(t);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
